// File: rtl/pwm_capture_pkg.sv
// ----------------------------------------------------------------------------
// pwm_capture_pkg : shared channel state encoding and saturation constant
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef PWM_CAPTURE_PKG_SV
`define PWM_CAPTURE_PKG_SV

`define PWM_CAPTURE_ALL_ONES(w) {(w){1'b1}}

package pwm_capture_pkg;

  localparam int c_state_w = 1;

  typedef enum logic [c_state_w-1:0] {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } chan_state_e;

endpackage

`endif

`default_nettype wire

// File: rtl/pwm_capture_if.sv
// ----------------------------------------------------------------------------
// pwm_capture_if : register read port of the PWM capture block
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pwm_capture_if #(
  parameter int Resolution   = 8,
  parameter int AddressWidth = 2
);

  logic [AddressWidth-1:0] addr;
  logic                    rd;
  logic [Resolution-1:0]   duty;
  logic [Resolution-1:0]   period;
  logic                    valid;
  logic                    overflow;
  logic                    fresh;

  modport master (
    output addr,
    output rd,
    input  duty,
    input  period,
    input  valid,
    input  overflow,
    input  fresh
  );

  modport slave (
    input  addr,
    input  rd,
    output duty,
    output period,
    output valid,
    output overflow,
    output fresh
  );

endinterface

`default_nettype wire

// File: rtl/pwm_capture_channel.sv
// ----------------------------------------------------------------------------
// pwm_capture_channel : synchronizer, edge detect and period/high-time capture
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pwm_capture_channel
  import pwm_capture_pkg::*;
#(
  parameter int Resolution = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  pwm_in,
  input  logic                  rd_hit,
  output logic [Resolution-1:0] duty,
  output logic [Resolution-1:0] period,
  output logic                  valid,
  output logic                  overflow,
  output logic                  fresh
);

  localparam logic [Resolution-1:0] c_all_ones = `PWM_CAPTURE_ALL_ONES(Resolution);
  localparam logic [Resolution-1:0] c_one      = Resolution'(1);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_prev;
  logic [Resolution-1:0] r_period_cnt;
  logic [Resolution-1:0] r_high_cnt;
  chan_state_e           r_state;
  logic                  w_rise;

  // The synchronizer runs every clock; only edge detection is gated by ce.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rise = ce & r_sync2 & ~r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_prev       <= 1'b0;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      duty         <= '0;
      period       <= '0;
      valid        <= 1'b0;
      overflow     <= 1'b0;
      fresh        <= 1'b0;
    end else begin
      // Read clear comes first so a coincident latch or timeout wins.
      if (rd_hit) begin
        fresh    <= 1'b0;
        overflow <= 1'b0;
      end
      if (ce) begin
        r_prev <= r_sync2;
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_period_cnt <= c_one;
              r_high_cnt   <= c_one;
              r_state      <= ST_MEAS;
            end
          end
          ST_MEAS: begin
            if (w_rise) begin
              period       <= r_period_cnt;
              duty         <= r_high_cnt;
              valid        <= 1'b1;
              fresh        <= 1'b1;
              r_period_cnt <= c_one;
              r_high_cnt   <= c_one;
            end else if (r_period_cnt != c_all_ones) begin
              r_period_cnt <= r_period_cnt + c_one;
              if (r_sync2) begin
                r_high_cnt <= r_high_cnt + c_one;
              end
            end else begin
              period       <= c_all_ones;
              duty         <= r_sync2 ? c_all_ones : '0;
              valid        <= 1'b1;
              fresh        <= 1'b1;
              overflow     <= 1'b1;
              r_period_cnt <= '0;
              r_high_cnt   <= '0;
              r_state      <= ST_IDLE;
            end
          end
          default: begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ----------------------------------------------------------------------------
// pwm_capture : multi-channel PWM capture with addressed one-cycle read port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int Resolution   = 8,
  parameter int AddressWidth = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [2**AddressWidth-1:0] I,
  pwm_capture_if.slave               bus
);

  localparam int c_num_chan = 2**AddressWidth;

  logic [Resolution-1:0] w_duty   [c_num_chan];
  logic [Resolution-1:0] w_period [c_num_chan];
  logic [c_num_chan-1:0] w_valid;
  logic [c_num_chan-1:0] w_overflow;
  logic [c_num_chan-1:0] w_fresh;
  logic [c_num_chan-1:0] w_hit;

  logic [Resolution-1:0] r_duty;
  logic [Resolution-1:0] r_period;
  logic                  r_valid;
  logic                  r_overflow;
  logic                  r_fresh;

  generate
    for (genvar gi = 0; gi < c_num_chan; gi++) begin : g_chan
      assign w_hit[gi] = bus.rd && (bus.addr == AddressWidth'(gi));

      pwm_capture_channel #(
        .Resolution (Resolution)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .pwm_in   (I[gi]),
        .rd_hit   (w_hit[gi]),
        .duty     (w_duty[gi]),
        .period   (w_period[gi]),
        .valid    (w_valid[gi]),
        .overflow (w_overflow[gi]),
        .fresh    (w_fresh[gi])
      );
    end
  endgenerate

  // Outputs capture pre-edge channel state, so a coincident latch is seen on the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_duty     <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_fresh    <= 1'b0;
    end else if (bus.rd) begin
      r_duty     <= w_duty[bus.addr];
      r_period   <= w_period[bus.addr];
      r_valid    <= w_valid[bus.addr];
      r_overflow <= w_overflow[bus.addr];
      r_fresh    <= w_fresh[bus.addr];
    end
  end

  assign bus.duty     = r_duty;
  assign bus.period   = r_period;
  assign bus.valid    = r_valid;
  assign bus.overflow = r_overflow;
  assign bus.fresh    = r_fresh;

endmodule

`default_nettype wire
